// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with arbitrary (non power-of-two) depth and count-decoded status flags.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default build uses registered reads.
module param_sync_fifo #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       write_en,
    input  logic                       read_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       data_valid,
    output logic                       full,
    output logic                       almost_full,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_acc;
    logic             rd_acc;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT) && !full;
    assign almost_empty = (count <= AE_CNT) && !empty;

    // A write into a full FIFO still lands when the same edge pops a word.
    assign rd_acc = read_en && !empty;
    assign wr_acc = write_en && (!full || read_en);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write_en && !wr_acc;
            underflow <= read_en && empty;
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo against a queue-based reference model.
// Covers both read modes; the FWFT build runs with DEPTH=5.
module tb_param_sync_fifo;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    localparam int D = 5;
`else
    localparam int D = 8;
`endif
    localparam int W  = 16;
    localparam int AF = 2;
    localparam int AE = 2;
    localparam int CW = $clog2(D+1);
    localparam int VW = 6 + CW + 1 + W;

    logic          clk = 1'b0;
    logic          rst;
    logic          write_en;
    logic          read_en;
    logic [W-1:0]  data_in;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          full, almost_full, empty, almost_empty;
    logic [CW-1:0] count;
    logic          overflow, underflow;

    param_sync_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .full(full), .almost_full(almost_full), .empty(empty),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // reference model
    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    bit           m_dv, m_ovf, m_udf;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [VW-1:0] exp_vec();
        int n;
        logic [W-1:0] d;
        bit v;
        n = q.size();
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        v = (n != 0);
        d = (n != 0) ? q[0] : '0;
`else
        v = m_dv;
        d = m_dout;
`endif
        return {(n == D), (n >= D - AF) && (n != D), (n == 0), (n <= AE) && (n != 0),
                m_ovf, m_udf, CW'(n), v, d};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        logic [W-1:0] d;
        d = data_out;
`ifdef PARAM_SYNC_FIFO_FWFT_EN
        if (q.size() == 0) d = '0;
`endif
        return {full, almost_full, empty, almost_empty, overflow, underflow, count, data_valid, d};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endfunction

    // Drive one cycle starting at a falling edge; model follows the rising edge.
    task automatic cycle_io(input bit we, input bit re, input logic [W-1:0] din);
        int  n;
        bit  wacc, racc;
        write_en = we;
        read_en  = re;
        data_in  = din;
        @(posedge clk);
        n     = q.size();
        racc  = re && (n != 0);
        wacc  = we && ((n != D) || re);
        m_ovf = we && !wacc;
        m_udf = re && (n == 0);
        m_dv  = racc;
        if (racc) m_dout = q.pop_front();
        if (wacc) q.push_back(din);
        @(negedge clk);
    endtask

    task automatic to_level(input int lvl);
        for (int k = 0; k < 4 * D && q.size() > lvl; k++) cycle_io(0, 1, '0);
        for (int k = 0; k < 4 * D && q.size() < lvl; k++) cycle_io(1, 0, W'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        write_en = 1'b0;
        read_en = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset got %h exp %h", obs_vec(), exp_vec());
        end
        rst = 1'b1;
        cycle_io(1, 0, 16'h00A5);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL first_write got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_fill();
        to_level(0);
        for (int i = 1; i <= D; i++) begin
            cycle_io(1, 0, W'(i));
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fill[%0d] got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        cycle_io(1, 0, 16'h00EE);
        n_tests++;
        if (overflow !== 1'b1 || count !== CW'(D) || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL overflow got %h exp %h", obs_vec(), exp_vec());
        end
        cycle_io(0, 0, '0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL overflow_clear got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= D; i++) begin
            cycle_io(0, 1, '0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL drain[%0d] got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
        cycle_io(0, 1, '0);
        n_tests++;
        if (underflow !== 1'b1 || empty !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL underflow got %h exp %h", obs_vec(), exp_vec());
        end
        cycle_io(0, 0, '0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL underflow_clear got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        to_level(3);
        for (int i = 0; i < 20; i++) begin
            cycle_io(1, 1, W'(16'h0100 + i));
            n_tests++;
            if (count !== CW'(3) || obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b[%0d] got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_simul_edges();
        to_level(0);
        cycle_io(1, 1, 16'h0BEE);
        n_tests++;
        if (count !== CW'(1) || underflow !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rw_empty got %h exp %h", obs_vec(), exp_vec());
        end
        to_level(D);
        cycle_io(1, 1, 16'h0CAF);
        n_tests++;
        if (count !== CW'(D) || overflow !== 1'b0 || underflow !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL rw_full got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit we, re;
        for (int i = 0; i < 400; i++) begin
            we = ($urandom_range(0, 99) < ((i < 200) ? 70 : 30));
            re = ($urandom_range(0, 99) < ((i < 200) ? 30 : 70));
            cycle_io(we, re, W'($urandom));
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random[%0d] got %h exp %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        to_level(5 < D ? 5 : D - 1);
        cycle_io(0, 1, '0);
        cycle_io(1, 0, 16'h0055);
        write_en = 1'b1;
        read_en  = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_reset got %h exp %h", obs_vec(), exp_vec());
        end
        write_en = 1'b0;
        read_en  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle_io(1, 0, 16'h0777);
        cycle_io(0, 1, '0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simul_edges();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule
